uart_core: RTL and testbench
============================

# uart_core

Parametrised single-clock UART transceiver: one full-duplex TX/RX pair sharing a programmable baud-tick generator, with configurable data width, oversampling ratio, optional parity and one or two stop bits. It replaces the dual-clock UART wrapper in the control-system datapath. The register block drives it directly. No external baud clocks are needed.

## Interface
- DATA_WIDTH, 8, payload bits per frame (5..9)
- DIV_WIDTH, 16, width of Baud_Div
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- Baud_Div  in  DIV_WIDTH  CLK cycles per oversample tick; 0 treated as 1
- Prescale  in  6  oversample ticks per bit; bit 0 ignored; values <4 treated as 4
- PAR_EN  in  1  parity bit present
- PAR_TYP  in  1  0 even, 1 odd
- STOP2  in  1  TX sends two stop bits
- Data_Valid_TX  in  1  TX request; accepted only when Busy=0
- P_DATA_TX  in  DATA_WIDTH  TX payload, sampled on acceptance
- TX_OUT  out  1  serial output, idle high
- Busy  out  1  TX frame in progress
- RX_IN  in  1  serial input, asynchronous
- P_DATA_RX  out  DATA_WIDTH  last received payload
- data_valid_RX  out  1  one-cycle pulse, error-free frame
- Parity_error  out  1  one-cycle pulse
- Framing_error  out  1  one-cycle pulse

## Operation
- Tick generator: free-running counter 0..max(Baud_Div,1)-1. The tick pulses one CLK at terminal count. TX and RX share the tick.
- Config (Prescale, PAR_EN, PAR_TYP, STOP2) is latched per direction at frame start. Mid-frame changes have no effect.
- Frame: start(0), DATA_WIDTH bits LSB first, optional parity, stop(1). Parity bit = ^data XOR PAR_TYP.
- TX FSM: IDLE -> START -> DATA -> PARITY (if PAR_EN) -> STOP -> STOP2 (if STOP2) -> IDLE.
  - Each state lasts P ticks, where P is the effective Prescale.
  - Data_Valid_TX while Busy=1 is ignored, with no queueing.
- RX path: 2-flop synchronizer on RX_IN, reset value 1.
- RX FSM: IDLE -> START -> DATA -> PARITY (if PAR_EN) -> STOP -> IDLE.
  - Start is detected on synchronized low in IDLE.
  - Each bit is sampled at ticks P/2-1, P/2, P/2+1 after bit start, using a 2-of-3 majority.
  - False start: majority 1 at start-bit centre -> return to IDLE, no output pulse.
  - STOP majority 0 -> Framing_error.
  - Parity mismatch -> Parity_error.
  - RX checks only one stop bit. After the stop-bit decision it returns to IDLE, ready for the next start edge.
- Frame end: P_DATA_RX is updated on every completed frame, errored or not. Error pulses and data_valid_RX fire in the same cycle. data_valid_RX=1 only if both errors are 0. Both errors may pulse together.

## Timing
- Reset values: TX_OUT=1, Busy=0, P_DATA_RX=0, data_valid_RX=0, Parity_error=0, Framing_error=0, tick counter=0, both FSMs IDLE, synchronizer=1.
- Reset asserted mid-frame aborts immediately and asynchronously: TX_OUT high, no RX pulses.
- TX acceptance: Busy=1 and TX_OUT=0 on the CLK after Data_Valid_TX=1 with Busy=0.
- TX bit period is P ticks. The first tick may arrive 1..Baud_Div CLK after acceptance, so the start bit is up to Baud_Div-1 CLK longer.
- Busy falls on the CLK after the final stop bit ends. A new request is accepted in that same cycle or later.
- RX latency: RX_IN edge reaches the FSM 2 CLK later. Output pulses occur one CLK after the stop-bit majority sample.
- Simultaneous TX and RX activity is fully independent.

## Structure
- Package uart_pkg holds:
  - tx_state_t and rx_state_t enums
  - MIN_PRESCALE=4
  - parity function par_bit(data, typ)
- Sub-module uart_baud_tick (CLK, RST, Baud_Div -> tick) is instantiated once. TX and RX FSMs live in uart_core.

## Test plan
- Reset check: assert RST low mid-frame -> all outputs return to reset values within the same cycle. Release -> TX_OUT stays 1 and there are no pulses.
- Loopback 0xA5: TX_OUT tied to RX_IN, Baud_Div=4, Prescale=8, no parity, STOP2=0.
  - Frame spans 320 CLK ±3.
  - Busy is high throughout.
  - data_valid_RX pulses once with P_DATA_RX=0xA5 and no errors.
- Loopback 0x3C: PAR_EN=1, PAR_TYP=1, STOP2=1. TX parity bit=1, Busy lasts 12 bit periods, RX gets 0x3C valid.
- Errors:
  - Inject frame 0x55 with even parity bit flipped -> Parity_error pulse, P_DATA_RX=0x55, no data_valid_RX.
  - Drive stop bit low -> Framing_error pulse.
- Glitches:
  - Start glitch of 2 ticks at Prescale=16 -> no pulse, RX back in IDLE.
  - Single-tick glitch mid data bit -> majority masks it, correct data.
- Request during Busy: Data_Valid_TX pulsed while Busy -> ignored, frame unchanged. Request on the cycle Busy falls -> accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, constants and parity helper for the UART transceiver.
package uart_pkg;

  localparam int MIN_PRESCALE   = 4;
  localparam int MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Callers zero-extend narrower payloads, which leaves the XOR unchanged.
  function automatic logic par_bit(input logic [MAX_DATA_WIDTH-1:0] data, input logic typ);
    return (^data) ^ typ;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every max(Baud_Div,1) clocks.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DIV_WIDTH-1:0] Baud_Div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] last;

  assign last = (Baud_Div == '0) ? '0 : Baud_Div - DIV_WIDTH'(1);
  // >= so a divider lowered below the running count wraps at once
  assign tick = (cnt >= last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + DIV_WIDTH'(1);
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: TX and RX FSMs sharing one oversample tick generator.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DIV_WIDTH-1:0]  Baud_Div,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  Data_Valid_TX,
  input  logic [DATA_WIDTH-1:0] P_DATA_TX,
  output logic                  TX_OUT,
  output logic                  Busy,
  input  logic                  RX_IN,
  output logic [DATA_WIDTH-1:0] P_DATA_RX,
  output logic                  data_valid_RX,
  output logic                  Parity_error,
  output logic                  Framing_error
);

  function automatic logic [5:0] eff_prescale(input logic [5:0] p);
    logic [5:0] e;
    e = p & 6'b111110;
    return (e < 6'(MIN_PRESCALE)) ? 6'(MIN_PRESCALE) : e;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] widen(input logic [DATA_WIDTH-1:0] d);
    logic [MAX_DATA_WIDTH-1:0] w;
    w = '0;
    w[DATA_WIDTH-1:0] = d;
    return w;
  endfunction

  logic tick;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .CLK      (CLK),
    .RST      (RST),
    .Baud_Div (Baud_Div),
    .tick     (tick)
  );

  tx_state_t             tx_state;
  logic [5:0]            tx_p, tx_cnt;
  logic [3:0]            tx_bit;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par_en, tx_stop2, tx_par;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state  <= TX_IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      tx_p      <= 6'(MIN_PRESCALE);
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par_en <= 1'b0;
      tx_stop2  <= 1'b0;
      tx_par    <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: if (Data_Valid_TX) begin
          tx_state  <= TX_START;
          TX_OUT    <= 1'b0;
          Busy      <= 1'b1;
          tx_p      <= eff_prescale(Prescale);
          tx_cnt    <= '0;
          tx_shift  <= P_DATA_TX;
          tx_par_en <= PAR_EN;
          tx_stop2  <= STOP2;
          tx_par    <= par_bit(widen(P_DATA_TX), PAR_TYP);
        end
        default: if (tick) begin
          if (tx_cnt != tx_p - 6'd1) begin
            tx_cnt <= tx_cnt + 6'd1;
          end else begin
            tx_cnt <= '0;
            case (tx_state)
              TX_START: begin
                tx_state <= TX_DATA;
                TX_OUT   <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_bit   <= 4'd1;
              end
              TX_DATA: begin
                if (tx_bit == 4'(DATA_WIDTH)) begin
                  tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                  TX_OUT   <= tx_par_en ? tx_par : 1'b1;
                end else begin
                  TX_OUT   <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= tx_bit + 4'd1;
                end
              end
              TX_PARITY: begin
                tx_state <= TX_STOP;
                TX_OUT   <= 1'b1;
              end
              TX_STOP: begin
                tx_state <= tx_stop2 ? TX_STOP2 : TX_IDLE;
                Busy     <= tx_stop2;
              end
              default: begin
                tx_state <= TX_IDLE;
                Busy     <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  logic [1:0]            rx_sync;
  logic                  rx_s, rx_s0, rx_s1, rx_maj;
  rx_state_t             rx_state;
  logic [5:0]            rx_p, rx_cnt, rx_half;
  logic [3:0]            rx_bit;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_par_en, rx_par_typ, rx_par_err;

  assign rx_s    = rx_sync[1];
  assign rx_half = {1'b0, rx_p[5:1]};
  assign rx_maj  = (rx_s0 & rx_s1) | (rx_s0 & rx_s) | (rx_s1 & rx_s);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_sync       <= 2'b11;
      rx_state      <= RX_IDLE;
      rx_p          <= 6'(MIN_PRESCALE);
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_s0         <= 1'b1;
      rx_s1         <= 1'b1;
      rx_par_en     <= 1'b0;
      rx_par_typ    <= 1'b0;
      rx_par_err    <= 1'b0;
      P_DATA_RX     <= '0;
      data_valid_RX <= 1'b0;
      Parity_error  <= 1'b0;
      Framing_error <= 1'b0;
    end else begin
      rx_sync       <= {rx_sync[0], RX_IN};
      data_valid_RX <= 1'b0;
      Parity_error  <= 1'b0;
      Framing_error <= 1'b0;
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_state   <= RX_START;
          rx_p       <= eff_prescale(Prescale);
          rx_cnt     <= '0;
          rx_par_en  <= PAR_EN;
          rx_par_typ <= PAR_TYP;
          rx_par_err <= 1'b0;
        end
        default: if (tick) begin
          rx_cnt <= (rx_cnt == rx_p - 6'd1) ? 6'd0 : rx_cnt + 6'd1;
          if (rx_cnt == rx_half - 6'd2) rx_s0 <= rx_s;
          if (rx_cnt == rx_half - 6'd1) rx_s1 <= rx_s;
          // Third sample tick: majority decision for the current bit
          if (rx_cnt == rx_half) begin
            case (rx_state)
              RX_START:  if (rx_maj) rx_state <= RX_IDLE;
              RX_DATA:   rx_shift <= {rx_maj, rx_shift[DATA_WIDTH-1:1]};
              RX_PARITY: rx_par_err <= rx_maj ^ par_bit(widen(rx_shift), rx_par_typ);
              RX_STOP: begin
                rx_state      <= RX_IDLE;
                P_DATA_RX     <= rx_shift;
                Framing_error <= ~rx_maj;
                Parity_error  <= rx_par_en & rx_par_err;
                data_valid_RX <= rx_maj & ~(rx_par_en & rx_par_err);
              end
              default: ;
            endcase
          end
          if (rx_cnt == rx_p - 6'd1) begin
            case (rx_state)
              RX_START: begin
                rx_state <= RX_DATA;
                rx_bit   <= '0;
              end
              RX_DATA: begin
                if (rx_bit == 4'(DATA_WIDTH - 1))
                  rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                else
                  rx_bit <= rx_bit + 4'd1;
              end
              RX_PARITY: rx_state <= RX_STOP;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback frames, injected errors, glitches, reset.
module tb_uart_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] Baud_Div = 16'd4;
  logic [5:0]  Prescale = 6'd8;
  logic        PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
  logic        Data_Valid_TX = 1'b0;
  logic [7:0]  P_DATA_TX = 8'h00;
  logic        TX_OUT, Busy;
  logic [7:0]  P_DATA_RX;
  logic        data_valid_RX, Parity_error, Framing_error;
  logic        loop_en = 1'b0, rx_drv = 1'b1;
  wire         RX_IN = loop_en ? TX_OUT : rx_drv;

  uart_core #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Baud_Div      (Baud_Div),
    .Prescale      (Prescale),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .STOP2         (STOP2),
    .Data_Valid_TX (Data_Valid_TX),
    .P_DATA_TX     (P_DATA_TX),
    .TX_OUT        (TX_OUT),
    .Busy          (Busy),
    .RX_IN         (RX_IN),
    .P_DATA_RX     (P_DATA_RX),
    .data_valid_RX (data_valid_RX),
    .Parity_error  (Parity_error),
    .Framing_error (Framing_error)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int dv_cnt = 0, pe_cnt = 0, fe_cnt = 0;

  always @(negedge CLK) begin
    if (data_valid_RX === 1'b1) dv_cnt <= dv_cnt + 1;
    if (Parity_error  === 1'b1) pe_cnt <= pe_cnt + 1;
    if (Framing_error === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
    $display("check %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
  endtask

  // Caller is at a negedge; bits[k] samples the middle of bit k (32 CLK per bit).
  task automatic tx_frame(input logic [7:0] d, input bit intrude,
                          output int cyc, output logic [11:0] bits);
    P_DATA_TX = d;
    Data_Valid_TX = 1'b1;
    @(negedge CLK);
    Data_Valid_TX = 1'b0;
    check("accept_busy", 32'(Busy), 32'd1);
    check("accept_txout", 32'(TX_OUT), 32'd0);
    cyc = 0;
    bits = '0;
    while (Busy === 1'b1 && cyc < 2000) begin
      for (int k = 0; k < 12; k++) if (cyc == 32 * k + 16) bits[k] = TX_OUT;
      if (intrude && cyc == 100) begin
        P_DATA_TX = 8'hFF;
        Data_Valid_TX = 1'b1;
      end
      if (intrude && cyc == 101) Data_Valid_TX = 1'b0;
      cyc++;
      @(negedge CLK);
    end
    check("tx_done_in_time", 32'(cyc < 2000), 32'd1);
  endtask

  task automatic send_rx(input logic [11:0] bits, input int n, input int blen,
                         input int gbit, input int gat, input int glen);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < blen; c++) begin
        rx_drv = (i == gbit && c >= gat && c < gat + glen) ? ~bits[i] : bits[i];
        @(negedge CLK);
      end
    end
    rx_drv = 1'b1;
    repeat (2 * blen) @(negedge CLK);
  endtask

  int          cyc, dv0, pe0, fe0, tx_low;
  logic [11:0] bits;

  initial begin
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_txout", 32'(TX_OUT), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_pdata", 32'(P_DATA_RX), 32'd0);
    check("rst_dv", 32'(data_valid_RX), 32'd0);
    check("rst_pe", 32'(Parity_error), 32'd0);
    check("rst_fe", 32'(Framing_error), 32'd0);
    RST = 1'b1;
    repeat (5) @(negedge CLK);

    // Loopback 0xA5, 8N1
    loop_en = 1'b1;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    tx_frame(8'hA5, 1'b0, cyc, bits);
    repeat (60) @(negedge CLK);
    check_range("a5_busy_cycles", cyc, 317, 323);
    check("a5_tx_bits", 32'(bits[9:0]), 32'h34A);
    check("a5_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    check("a5_err_pulses", 32'(pe_cnt - pe0 + fe_cnt - fe0), 32'd0);
    check("a5_rx_data", 32'(P_DATA_RX), 32'hA5);

    // Loopback 0x3C, odd parity, two stop bits
    PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    tx_frame(8'h3C, 1'b0, cyc, bits);
    repeat (60) @(negedge CLK);
    check_range("3c_busy_cycles", cyc, 381, 387);
    check("3c_parity_bit", 32'(bits[9]), 32'd1);
    check("3c_tx_bits", 32'(bits), 32'hE78);
    check("3c_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    check("3c_err_pulses", 32'(pe_cnt - pe0 + fe_cnt - fe0), 32'd0);
    check("3c_rx_data", 32'(P_DATA_RX), 32'h3C);

    // Asynchronous reset in the middle of a 0x00 frame
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    P_DATA_TX = 8'h00;
    Data_Valid_TX = 1'b1;
    @(negedge CLK);
    Data_Valid_TX = 1'b0;
    repeat (100) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("midrst_txout", 32'(TX_OUT), 32'd1);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_pdata", 32'(P_DATA_RX), 32'd0);
    check("midrst_pulses", 32'({data_valid_RX, Parity_error, Framing_error}), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    tx_low = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1) tx_low++;
    end
    check("postrst_tx_low_cycles", 32'(tx_low), 32'd0);
    check("postrst_pulses", 32'(dv_cnt - dv0 + pe_cnt - pe0 + fe_cnt - fe0), 32'd0);

    // Injected 0x55 with flipped even parity bit
    loop_en = 1'b0;
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_rx({1'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 11, 32, -1, 0, 0);
    check("par_pe_pulses", 32'(pe_cnt - pe0), 32'd1);
    check("par_dv_pulses", 32'(dv_cnt - dv0), 32'd0);
    check("par_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
    check("par_rx_data", 32'(P_DATA_RX), 32'h55);

    // Stop bit driven low
    PAR_EN = 1'b0;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_rx({2'b00, 1'b0, 8'h5A, 1'b0}, 10, 32, -1, 0, 0);
    check("frm_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("frm_dv_pulses", 32'(dv_cnt - dv0), 32'd0);
    check("frm_pe_pulses", 32'(pe_cnt - pe0), 32'd0);
    check("frm_rx_data", 32'(P_DATA_RX), 32'h5A);

    // One-tick glitch in the middle of data bit 0
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_rx({2'b00, 1'b1, 8'hA5, 1'b0}, 10, 32, 1, 14, 4);
    check("glitch_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    check("glitch_err_pulses", 32'(pe_cnt - pe0 + fe_cnt - fe0), 32'd0);
    check("glitch_rx_data", 32'(P_DATA_RX), 32'hA5);

    // Two-tick start glitch at Prescale 16, then a real frame
    Prescale = 6'd16;
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    rx_drv = 1'b0;
    repeat (8) @(negedge CLK);
    rx_drv = 1'b1;
    repeat (700) @(negedge CLK);
    check("falsestart_pulses", 32'(dv_cnt - dv0 + pe_cnt - pe0 + fe_cnt - fe0), 32'd0);
    send_rx({2'b00, 1'b1, 8'hC3, 1'b0}, 10, 64, -1, 0, 0);
    check("p16_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    check("p16_rx_data", 32'(P_DATA_RX), 32'hC3);

    // Request during Busy is dropped; request on the Busy-fall cycle is taken
    Prescale = 6'd8;
    loop_en = 1'b1;
    dv0 = dv_cnt;
    tx_frame(8'h0F, 1'b1, cyc, bits);
    check("intrude_tx_bits", 32'(bits[9:0]), 32'h21E);
    check("intrude_rx_data", 32'(P_DATA_RX), 32'h0F);
    tx_frame(8'h81, 1'b0, cyc, bits);
    repeat (60) @(negedge CLK);
    check("chain_tx_bits", 32'(bits[9:0]), 32'h302);
    check("chain_rx_data", 32'(P_DATA_RX), 32'h81);
    check("chain_dv_pulses", 32'(dv_cnt - dv0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
